alu_control_md: RTL and testbench
=================================

// Module: alu_control_md
// PURPOSE
//  EX-stage ALU control, second generation. Decodes funct/opcode into the ALU op code and the shamt select.
//  Adds an iterative multiply/divide sequencer with HI/LO registers (MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO).
//  Raises a pipeline stall while a HI/LO-dependent instruction would collide with an in-flight op.
// PARAMETERS
//  DATA_W        32       operand width; HI and LO are DATA_W each
//  BITS_ALU      6        funct/opcode width
//  BITS_ALU_CTL  2        main-control ALU class width
//  ALU_OP        4        ALU op code width
// PORTS
//  i_clk          in   1             clock, rising edge
//  i_rst_n        in   1             asynchronous, active-low reset
//  i_valid        in   1             instruction present in EX
//  i_flush        in   1             EX instruction squashed; blocks start and HI/LO writes this cycle
//  i_funct        in   BITS_ALU      R-type funct
//  i_opcode       in   BITS_ALU      opcode
//  i_unit_alu_op  in   BITS_ALU_CTL  00 add, 01 sub, 10 R-type, 11 immediate
//  i_rs_data      in   DATA_W        rs operand (dividend/multiplicand, MTHI/MTLO source)
//  i_rt_data      in   DATA_W        rt operand
//  o_alu_op       out  ALU_OP        ADD 0000 SUB 0001 AND 0010 OR 0011 NOR 0100 XOR 0101 SLTU 0110 SLT 0111 SLL 1000 SRL 1001 SRA 1011 LUI 1100 ILLEGAL 1111
//  o_shamt        out  1             shift amount taken from the instruction shamt field
//  o_illegal      out  1             no decode match
//  o_hilo_sel     out  1             EX result comes from o_hilo_data (MFHI/MFLO)
//  o_hilo_data    out  DATA_W        HI for MFHI, LO for MFLO, else 0
//  o_stall        out  1             hold IF/ID/EX this cycle
//  o_md_busy      out  1             sequencer not IDLE
//  o_div_zero     out  1             one-cycle pulse: divide by zero completed
// BEHAVIOUR
//  Decode (combinational, no latency):
//   - 00 -> ADD; 01 -> SUB.
//   - 10: ADD/ADDU -> ADD; SUB/SUBU -> SUB; AND; OR; NOR; XOR; SLT; SLTU(101011) -> SLTU; SLL/SLLV; SRL/SRLV; SRA/SRAV.
//     MF*/MT*/MULT*/DIV* -> 0000, not illegal.
//   - 11: ADDI/ADDIU -> ADD; SLTI -> SLT; SLTIU -> SLTU; ANDI; ORI; XORI; LUI(001111) -> LUI.
//   - No match -> 1111 with o_illegal=1.
//   - o_shamt=1 only when class=10 and funct is SLL/SRL/SRA.
//  MD ops: MULT 011000, MULTU 011001, DIV 011010, DIVU 011011, MFHI 010000, MTHI 010001, MFLO 010010, MTLO 010011.
//  fire = i_valid & ~i_flush & ~o_stall & class==10.
//  o_stall = i_valid & class==10 & (any MD op) & state!=IDLE.
//  FSM: IDLE -(fire & MULT*/DIV*)-> RUN; RUN counts DATA_W cycles -> DONE; DONE -> IDLE.
//   - Edge entering RUN latches |operands| and the sign info.
//   - One shift-add (mult) or restoring-subtract (div) step per RUN cycle.
//   - DONE: sign fix-up, then HI/LO written on the DONE->IDLE edge.
//   - Latency: HI/LO are readable DATA_W+1 cycles after the start edge. A dependent op issued the next cycle stalls exactly DATA_W+1 cycles.
//  Arithmetic:
//   - MULT/MULTU: {HI,LO} = 2*DATA_W product. Signed result negated when operand signs differ.
//   - DIV/DIVU: LO = quotient truncated toward zero; HI = remainder, with the sign of the dividend.
//   - Divide by zero: LO = all ones, HI = dividend; o_div_zero pulses in DONE.
//   - Signed most-negative operands handled in DATA_W+1-bit magnitude; no overflow trap.
//  MTHI/MTLO: on fire, HI or LO <= i_rs_data at the clock edge.
//  MFHI/MFLO: o_hilo_sel=1, o_hilo_data = register value (combinational).
//  Flush: blocks start and MT* writes in the same cycle only. An op already in RUN/DONE always completes.
//  Reset (async, any state): state IDLE, counter 0, HI=LO=0, o_md_busy=0, o_div_zero=0, o_stall=0.
//   Decode outputs follow their inputs.
// STRUCTURE
//  Package mips_alu_pkg: funct/opcode constants, ALU op codes, class codes, md_state_t enum.
//  Sub-module md_iter_unit: iterative mult/div datapath and counter, start/done handshake.
//   Top keeps decode, stall logic and HI/LO.
// TESTING (DATA_W=32)
//  1 class=10, funct=100010 -> alu_op 0001, shamt 0; funct=000011 -> 1011, shamt 1; funct=111111 -> 1111, illegal 1.
//  2 MULT rs=0xFFFFFFFD, rt=7 -> busy 33 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFEB; MULTU same operands -> HI=0x00000006, LO=0xFFFFFFEB.
//  3 DIV rs=-7, rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7/2 -> LO=3, HI=1.
//  4 MFLO issued the cycle after MULT 5*6 -> o_stall high exactly 33 cycles, then hilo_sel=1, hilo_data=30.
//  5 DIVU 0x1234/0 -> one o_div_zero pulse, LO=0xFFFFFFFF, HI=0x1234; MTLO with i_flush=1 -> LO unchanged.
//  6 i_rst_n low mid-RUN -> busy=0 immediately, HI=LO=0; subsequent MULT 3*3 -> LO=9 after 33 cycles.

Source files
------------

// File: rtl/mips_alu_pkg.sv
// Shared constants for the EX-stage ALU control and the mult/div sequencer.
package mips_alu_pkg;

    // Main-control ALU class
    localparam logic [1:0] CLS_ADD   = 2'b00;
    localparam logic [1:0] CLS_SUB   = 2'b01;
    localparam logic [1:0] CLS_RTYPE = 2'b10;
    localparam logic [1:0] CLS_IMM   = 2'b11;

    // R-type funct codes
    localparam logic [5:0] F_SLL   = 6'b000000;
    localparam logic [5:0] F_SRL   = 6'b000010;
    localparam logic [5:0] F_SRA   = 6'b000011;
    localparam logic [5:0] F_SLLV  = 6'b000100;
    localparam logic [5:0] F_SRLV  = 6'b000110;
    localparam logic [5:0] F_SRAV  = 6'b000111;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_ADDU  = 6'b100001;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_SUBU  = 6'b100011;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_XOR   = 6'b100110;
    localparam logic [5:0] F_NOR   = 6'b100111;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_SLTU  = 6'b101011;

    // I-type opcodes
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;

    // ALU op codes
    localparam logic [3:0] ALU_ADD     = 4'b0000;
    localparam logic [3:0] ALU_SUB     = 4'b0001;
    localparam logic [3:0] ALU_AND     = 4'b0010;
    localparam logic [3:0] ALU_OR      = 4'b0011;
    localparam logic [3:0] ALU_NOR     = 4'b0100;
    localparam logic [3:0] ALU_XOR     = 4'b0101;
    localparam logic [3:0] ALU_SLTU    = 4'b0110;
    localparam logic [3:0] ALU_SLT     = 4'b0111;
    localparam logic [3:0] ALU_SLL     = 4'b1000;
    localparam logic [3:0] ALU_SRL     = 4'b1001;
    localparam logic [3:0] ALU_SRA     = 4'b1011;
    localparam logic [3:0] ALU_LUI     = 4'b1100;
    localparam logic [3:0] ALU_ILLEGAL = 4'b1111;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_RUN  = 2'd1,
        MD_DONE = 2'd2
    } md_state_t;

endpackage

// File: rtl/md_iter_unit.sv
// Iterative multiply/divide datapath: one shift-add or restoring-subtract step per cycle.
//  state   | meaning
//  MD_IDLE | waiting for start; result outputs hold the last op
//  MD_RUN  | DATA_W iteration steps on unsigned magnitudes
//  MD_DONE | sign-corrected result valid; caller captures HI/LO on leaving
module md_iter_unit
    import mips_alu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              div_i,
    input  logic              signed_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output md_state_t         state_o,
    output logic              done_o,
    output logic              div_zero_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);
    localparam int CNT_W = $clog2(DATA_W);

    md_state_t         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              div_q, div_d;
    logic              neg_p_q, neg_p_d;   // negate product / quotient
    logic              neg_r_q, neg_r_d;   // negate remainder
    logic              dz_q, dz_d;
    logic [DATA_W-1:0] mag_q, mag_d;       // multiplicand or divisor magnitude
    logic [DATA_W:0]   acc_q, acc_d;       // product upper half or partial remainder
    logic [DATA_W-1:0] lo_q, lo_d;         // multiplier / quotient shift register

    logic [DATA_W-1:0]   mag_a, mag_b;
    logic [DATA_W:0]     sum, rem_sh;
    logic [2*DATA_W-1:0] prod, prod_s;
    logic [DATA_W-1:0]   quo_s, rem_s;

    // Operand magnitudes; the most-negative value maps to 2^(DATA_W-1) unsigned
    assign mag_a  = (signed_i && a_i[DATA_W-1]) ? -a_i : a_i;
    assign mag_b  = (signed_i && b_i[DATA_W-1]) ? -b_i : b_i;
    assign sum    = acc_q + {1'b0, (lo_q[0] ? mag_q : '0)};
    assign rem_sh = {acc_q[DATA_W-1:0], lo_q[DATA_W-1]};

    // Next-state and iteration step
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        neg_p_d = neg_p_q;
        neg_r_d = neg_r_q;
        dz_d    = dz_q;
        mag_d   = mag_q;
        acc_d   = acc_q;
        lo_d    = lo_q;
        case (state_q)
            MD_IDLE: begin
                if (start_i) begin
                    state_d = MD_RUN;
                    cnt_d   = CNT_W'(DATA_W - 1);
                    div_d   = div_i;
                    neg_p_d = signed_i & (a_i[DATA_W-1] ^ b_i[DATA_W-1]);
                    neg_r_d = signed_i & a_i[DATA_W-1];
                    dz_d    = div_i & (b_i == '0);
                    mag_d   = div_i ? mag_b : mag_a;
                    lo_d    = div_i ? mag_a : mag_b;
                    acc_d   = '0;
                end
            end
            MD_RUN: begin
                if (div_q) begin
                    if (rem_sh >= {1'b0, mag_q}) begin
                        acc_d = rem_sh - {1'b0, mag_q};
                        lo_d  = {lo_q[DATA_W-2:0], 1'b1};
                    end else begin
                        acc_d = rem_sh;
                        lo_d  = {lo_q[DATA_W-2:0], 1'b0};
                    end
                end else begin
                    acc_d = {1'b0, sum[DATA_W:1]};
                    lo_d  = {sum[0], lo_q[DATA_W-1:1]};
                end
                if (cnt_q == '0) state_d = MD_DONE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            MD_DONE: state_d = MD_IDLE;
            default: state_d = MD_IDLE;
        endcase
    end

    // Sequencer and datapath registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
            div_q   <= 1'b0;
            neg_p_q <= 1'b0;
            neg_r_q <= 1'b0;
            dz_q    <= 1'b0;
            mag_q   <= '0;
            acc_q   <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            neg_p_q <= neg_p_d;
            neg_r_q <= neg_r_d;
            dz_q    <= dz_d;
            mag_q   <= mag_d;
            acc_q   <= acc_d;
            lo_q    <= lo_d;
        end
    end

    // Sign fix-up; divide by zero leaves HI = dividend and forces LO to all ones
    assign prod   = {acc_q[DATA_W-1:0], lo_q};
    assign prod_s = neg_p_q ? -prod : prod;
    assign quo_s  = neg_p_q ? -lo_q : lo_q;
    assign rem_s  = neg_r_q ? -acc_q[DATA_W-1:0] : acc_q[DATA_W-1:0];

    assign hi_o       = div_q ? rem_s : prod_s[2*DATA_W-1:DATA_W];
    assign lo_o       = div_q ? (dz_q ? '1 : quo_s) : prod_s[DATA_W-1:0];
    assign state_o    = state_q;
    assign done_o     = (state_q == MD_DONE);
    assign div_zero_o = (state_q == MD_DONE) && dz_q;

endmodule

// File: rtl/alu_control_md.sv
// EX-stage ALU control: op decode, HI/LO registers and stall against the mult/div sequencer.
module alu_control_md
    import mips_alu_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int BITS_ALU     = 6,
    parameter int BITS_ALU_CTL = 2,
    parameter int ALU_OP       = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_valid,
    input  logic                    i_flush,
    input  logic [BITS_ALU-1:0]     i_funct,
    input  logic [BITS_ALU-1:0]     i_opcode,
    input  logic [BITS_ALU_CTL-1:0] i_unit_alu_op,
    input  logic [DATA_W-1:0]       i_rs_data,
    input  logic [DATA_W-1:0]       i_rt_data,
    output logic [ALU_OP-1:0]       o_alu_op,
    output logic                    o_shamt,
    output logic                    o_illegal,
    output logic                    o_hilo_sel,
    output logic [DATA_W-1:0]       o_hilo_data,
    output logic                    o_stall,
    output logic                    o_md_busy,
    output logic                    o_div_zero
);
    logic              is_rtype, is_md, is_muldiv, stall, fire;
    md_state_t         md_state;
    logic              md_done;
    logic [DATA_W-1:0] md_hi, md_lo;
    logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d;

    // ALU op decode from class, funct and opcode
    always_comb begin
        o_alu_op  = ALU_ILLEGAL;
        o_illegal = 1'b1;
        o_shamt   = 1'b0;
        is_md     = 1'b0;
        case (i_unit_alu_op)
            CLS_ADD: begin o_alu_op = ALU_ADD; o_illegal = 1'b0; end
            CLS_SUB: begin o_alu_op = ALU_SUB; o_illegal = 1'b0; end
            CLS_RTYPE: begin
                o_illegal = 1'b0;
                case (i_funct)
                    F_ADD, F_ADDU: o_alu_op = ALU_ADD;
                    F_SUB, F_SUBU: o_alu_op = ALU_SUB;
                    F_AND:         o_alu_op = ALU_AND;
                    F_OR:          o_alu_op = ALU_OR;
                    F_NOR:         o_alu_op = ALU_NOR;
                    F_XOR:         o_alu_op = ALU_XOR;
                    F_SLT:         o_alu_op = ALU_SLT;
                    F_SLTU:        o_alu_op = ALU_SLTU;
                    F_SLL:  begin o_alu_op = ALU_SLL; o_shamt = 1'b1; end
                    F_SRL:  begin o_alu_op = ALU_SRL; o_shamt = 1'b1; end
                    F_SRA:  begin o_alu_op = ALU_SRA; o_shamt = 1'b1; end
                    F_SLLV:        o_alu_op = ALU_SLL;
                    F_SRLV:        o_alu_op = ALU_SRL;
                    F_SRAV:        o_alu_op = ALU_SRA;
                    F_MFHI, F_MTHI, F_MFLO, F_MTLO,
                    F_MULT, F_MULTU, F_DIV, F_DIVU: begin
                        o_alu_op = ALU_ADD;
                        is_md    = 1'b1;
                    end
                    default: begin o_alu_op = ALU_ILLEGAL; o_illegal = 1'b1; end
                endcase
            end
            CLS_IMM: begin
                o_illegal = 1'b0;
                case (i_opcode)
                    OP_ADDI, OP_ADDIU: o_alu_op = ALU_ADD;
                    OP_SLTI:           o_alu_op = ALU_SLT;
                    OP_SLTIU:          o_alu_op = ALU_SLTU;
                    OP_ANDI:           o_alu_op = ALU_AND;
                    OP_ORI:            o_alu_op = ALU_OR;
                    OP_XORI:           o_alu_op = ALU_XOR;
                    OP_LUI:            o_alu_op = ALU_LUI;
                    default: begin o_alu_op = ALU_ILLEGAL; o_illegal = 1'b1; end
                endcase
            end
            default: ;
        endcase
    end

    assign is_rtype  = (i_unit_alu_op == CLS_RTYPE);
    assign is_muldiv = is_md && (i_funct[5:2] == F_MULT[5:2]);
    // Any HI/LO-touching op waits until the sequencer has written its result
    assign stall     = i_valid && is_md && (md_state != MD_IDLE);
    assign fire      = i_valid && !i_flush && !stall && is_rtype;

    md_iter_unit #(.DATA_W(DATA_W)) u_md (
        .clk_i      (i_clk),
        .rst_ni     (i_rst_n),
        .start_i    (fire && is_muldiv),
        .div_i      (i_funct[1]),
        .signed_i   (~i_funct[0]),
        .a_i        (i_rs_data),
        .b_i        (i_rt_data),
        .state_o    (md_state),
        .done_o     (md_done),
        .div_zero_o (o_div_zero),
        .hi_o       (md_hi),
        .lo_o       (md_lo)
    );

    // HI/LO update: sequencer result on DONE exit, else MTHI/MTLO
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (md_done) begin
            hi_d = md_hi;
            lo_d = md_lo;
        end else if (fire) begin
            if (i_funct == F_MTHI) hi_d = i_rs_data;
            if (i_funct == F_MTLO) lo_d = i_rs_data;
        end
    end

    // HI/LO registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    assign o_hilo_sel  = is_rtype && (i_funct == F_MFHI || i_funct == F_MFLO);
    assign o_hilo_data = !is_rtype           ? '0   :
                         (i_funct == F_MFHI) ? hi_q :
                         (i_funct == F_MFLO) ? lo_q : '0;
    assign o_stall     = stall;
    assign o_md_busy   = (md_state != MD_IDLE);

endmodule

// File: tb/tb_alu_control_md.sv
module tb_alu_control_md;
    localparam int W   = 32;
    localparam int LAT = W + 1;

    logic         clk = 1'b0;
    logic         rst_n, valid, flush;
    logic [5:0]   funct, opcode;
    logic [1:0]   cls;
    logic [W-1:0] rs, rt;
    logic [3:0]   alu_op;
    logic         shamt, illegal, hilo_sel, stall, busy, div_zero;
    logic [W-1:0] hilo_data;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    alu_control_md #(.DATA_W(W)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_flush(flush),
        .i_funct(funct), .i_opcode(opcode), .i_unit_alu_op(cls),
        .i_rs_data(rs), .i_rt_data(rt),
        .o_alu_op(alu_op), .o_shamt(shamt), .o_illegal(illegal),
        .o_hilo_sel(hilo_sel), .o_hilo_data(hilo_data), .o_stall(stall),
        .o_md_busy(busy), .o_div_zero(div_zero)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Reference decode: {illegal, shamt, alu_op}
    function automatic logic [5:0] ref_dec(input logic [1:0] c, input logic [5:0] f, input logic [5:0] o);
        logic [3:0] op;
        logic       sh;
        op = 4'hF;
        sh = 1'b0;
        if (c == 2'd0) op = 4'h0;
        else if (c == 2'd1) op = 4'h1;
        else if (c == 2'd2) begin
            case (f)
                6'h20, 6'h21: op = 4'h0;
                6'h22, 6'h23: op = 4'h1;
                6'h24: op = 4'h2;
                6'h25: op = 4'h3;
                6'h27: op = 4'h4;
                6'h26: op = 4'h5;
                6'h2B: op = 4'h6;
                6'h2A: op = 4'h7;
                6'h00: begin op = 4'h8; sh = 1'b1; end
                6'h02: begin op = 4'h9; sh = 1'b1; end
                6'h03: begin op = 4'hB; sh = 1'b1; end
                6'h04: op = 4'h8;
                6'h06: op = 4'h9;
                6'h07: op = 4'hB;
                6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B: op = 4'h0;
                default: op = 4'hF;
            endcase
        end else begin
            case (o)
                6'h08, 6'h09: op = 4'h0;
                6'h0A: op = 4'h7;
                6'h0B: op = 4'h6;
                6'h0C: op = 4'h2;
                6'h0D: op = 4'h3;
                6'h0E: op = 4'h5;
                6'h0F: op = 4'hC;
                default: op = 4'hF;
            endcase
        end
        return {(op == 4'hF), sh, op};
    endfunction

    // Reference mult/div in plain 64-bit arithmetic
    task automatic ref_md(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] hi, output logic [W-1:0] lo);
        logic [63:0] p;
        longint sa, sb, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = '0;
        case (f)
            6'h18: p = 64'(sa * sb);
            6'h19: p = {32'd0, a} * {32'd0, b};
            6'h1A: begin
                if (b == 0) p = {a, 32'hFFFF_FFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    p = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == 0) p = {a, 32'hFFFF_FFFF};
                else p = {a % b, a / b};
            end
        endcase
        hi = p[63:32];
        lo = p[31:0];
    endtask

    task automatic read_hilo(input string tag, input logic [W-1:0] eh, input logic [W-1:0] el);
        cls   = 2'b10;
        valid = 1'b1;
        funct = 6'h10;
        #1;
        chk({tag, " mfhi sel"}, 64'(hilo_sel), 64'd1);
        chk({tag, " hi"}, 64'(hilo_data), 64'(eh));
        funct = 6'h12;
        #1;
        chk({tag, " lo"}, 64'(hilo_data), 64'(el));
        valid = 1'b0;
    endtask

    task automatic run_md(input string tag, input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] eh, el;
        int cyc, dz;
        ref_md(f, a, b, eh, el);
        @(negedge clk);
        valid = 1'b1; flush = 1'b0; cls = 2'b10; funct = f; rs = a; rt = b;
        @(negedge clk);
        valid = 1'b0;
        cyc = 0;
        dz  = 0;
        while (busy && cyc < 200) begin
            cyc++;
            if (div_zero) dz++;
            @(negedge clk);
        end
        chk({tag, " busy cycles"}, 64'(cyc), 64'(LAT));
        chk({tag, " div_zero pulses"}, 64'(dz), 64'((f[1] && b == 0) ? 1 : 0));
        read_hilo(tag, eh, el);
    endtask

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 6))
            0: return 32'h0000_0000;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'h7FFF_FFFF;
            4: return W'($urandom_range(0, 20));
            5: return -W'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    logic [5:0] fpool [20] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h10, 6'h11, 6'h12,
                               6'h13, 6'h18, 6'h1B, 6'h20, 6'h22, 6'h24, 6'h27, 6'h2A, 6'h2B,
                               6'h26, 6'h3F};

    initial begin
        logic [5:0] e;
        logic [5:0] mdops [4];
        int n;
        mdops = '{6'h18, 6'h19, 6'h1A, 6'h1B};

        rst_n = 1'b0; valid = 1'b0; flush = 1'b0;
        cls = 2'b10; funct = 6'h10; opcode = 6'h00; rs = '0; rt = '0;
        #1;
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset div_zero", 64'(div_zero), 64'd0);
        chk("reset stall", 64'(stall), 64'd0);
        chk("reset hi", 64'(hilo_data), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed decode
        cls = 2'b10; funct = 6'b100010; #1;
        chk("dec sub op", 64'(alu_op), 64'h1);
        chk("dec sub shamt", 64'(shamt), 64'd0);
        funct = 6'b000011; #1;
        chk("dec sra op", 64'(alu_op), 64'hB);
        chk("dec sra shamt", 64'(shamt), 64'd1);
        funct = 6'b111111; #1;
        chk("dec bad op", 64'(alu_op), 64'hF);
        chk("dec bad illegal", 64'(illegal), 64'd1);

        // Randomized decode against reference
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            cls    = 2'($urandom_range(0, 3));
            funct  = ($urandom_range(0, 3) != 0) ? fpool[$urandom_range(0, 19)] : 6'($urandom);
            opcode = ($urandom_range(0, 3) != 0) ? 6'($urandom_range(8, 16)) : 6'($urandom);
            #1;
            e = ref_dec(cls, funct, opcode);
            chk("rand dec", {57'd0, illegal, shamt, alu_op}, 64'(e));
            chk("rand hilo_sel", 64'(hilo_sel), 64'((cls == 2'b10) && (funct == 6'h10 || funct == 6'h12)));
        end

        // Directed mult/div
        run_md("mult neg", 6'h18, 32'hFFFF_FFFD, 32'd7);
        run_md("multu", 6'h19, 32'hFFFF_FFFD, 32'd7);
        run_md("div neg", 6'h1A, -32'd7, 32'd2);
        run_md("divu", 6'h1B, 32'd7, 32'd2);

        // Dependent MFLO stalls for the full latency
        @(negedge clk);
        valid = 1'b1; cls = 2'b10; funct = 6'h18; rs = 32'd5; rt = 32'd6;
        @(negedge clk);
        funct = 6'h12;
        #1;
        n = 0;
        while (stall && n < 200) begin
            n++;
            @(negedge clk);
            #1;
        end
        chk("stall cycles", 64'(n), 64'(LAT));
        chk("stall mflo sel", 64'(hilo_sel), 64'd1);
        chk("stall mflo data", 64'(hilo_data), 64'd30);
        valid = 1'b0;

        // Divide by zero, then flushed MTLO must not write, unflushed MTHI must
        run_md("divu by zero", 6'h1B, 32'h1234, 32'd0);
        @(negedge clk);
        valid = 1'b1; flush = 1'b1; cls = 2'b10; funct = 6'h13; rs = 32'hDEAD_BEEF;
        @(negedge clk);
        valid = 1'b1; flush = 1'b0; funct = 6'h11; rs = 32'hCAFE_0001;
        @(negedge clk);
        valid = 1'b0;
        read_hilo("mt flush", 32'hCAFE_0001, 32'hFFFF_FFFF);

        // Reset in the middle of RUN
        @(negedge clk);
        valid = 1'b1; cls = 2'b10; funct = 6'h18; rs = 32'd1234; rt = 32'd99;
        @(negedge clk);
        valid = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid-run reset busy", 64'(busy), 64'd0);
        read_hilo("mid-run reset", 32'd0, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_md("post-reset mult", 6'h18, 32'd3, 32'd3);

        // Randomized mult/div against reference
        for (int i = 0; i < 24; i++) begin
            run_md("rand md", mdops[$urandom_range(0, 3)], pick_operand(), pick_operand());
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
